// File: rtl/nexi_uart_rx_ctrl.sv
// nexi_uart_rx_ctrl: UART receiver ack handshake sequencer with byte FIFO and CPU register slave
module nexi_uart_rx_ctrl #(
  parameter int DEPTH_LOG2  = 3,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] uart_data,
  input  logic       uart_ready,
  output logic       uart_ack,
  input  logic       bus_rd,
  input  logic       bus_wr,
  input  logic [1:0] bus_addr,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       irq
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  typedef enum logic [1:0] {IDLE, ACK, GAP} state_t;
  state_t state_q, state_d;
  logic ack_q, ack_d;
  logic [7:0] tmr_q, tmr_d;
  logic push_req, err_set, tmo;
  logic [7:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic ovf_q, err_q, irq_en_q, irq_q;
  logic [7:0] rdata_q, rdata_d, status;
  logic [6:0] cnt_x;
  logic [3:0] cnt_sat;
  logic ne, full, rd_en, pop, flush, push_ok, ovf_set;
  assign tmo = tmr_q == 8'(ACK_TIMEOUT - 1);
  // handshake state, ack and timeout timer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q <= 1'b0;
      tmr_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q <= ack_d;
      tmr_q <= tmr_d;
    end
  end
  // next handshake state: ack ends on ready falling or on timeout, always followed by one low-ack gap cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = uart_ready ? ACK : IDLE;
      ACK:  state_d = (!uart_ready || tmo) ? GAP : ACK;
      default: state_d = IDLE;
    endcase
  end
  // handshake outputs: ack level, timer, single push on capture, stuck-receiver flag
  always_comb begin
    push_req = (state_q == IDLE) && uart_ready;
    ack_d = (state_q == IDLE) ? uart_ready : (state_q == ACK) ? (uart_ready && !tmo) : 1'b0;
    tmr_d = (state_q == ACK) ? tmr_q + 8'd1 : 8'd0;
    err_set = (state_q == ACK) && uart_ready && tmo;
  end
  assign ne = cnt_q != '0;
  assign full = cnt_q == CW'(DEPTH);
  assign rd_en = bus_rd && !bus_wr;
  assign pop = rd_en && (bus_addr == 2'd0) && ne;
  assign flush = bus_wr && (bus_addr == 2'd2) && bus_wdata[1];
  assign push_ok = push_req && !flush && (!full || pop);
  assign ovf_set = push_req && !flush && full && !pop;
  assign cnt_x = 7'(cnt_q);
  assign cnt_sat = (cnt_x > 7'd15) ? 4'd15 : cnt_x[3:0];
  assign status = {cnt_sat, err_q, ovf_q, full, ne};
  // read data mux; unaddressed or reserved reads return zero
  always_comb begin
    rdata_d = (bus_addr == 2'd0) ? (ne ? mem[rp_q] : 8'h00) :
              (bus_addr == 2'd1) ? status :
              (bus_addr == 2'd2) ? {7'b0, irq_en_q} : 8'h00;
  end
  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push_ok) mem[wp_q] <= uart_data;
  end
  // FIFO pointers, sticky flags, control register, read data and interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (flush) begin
        wp_q <= '0;
        rp_q <= '0;
        cnt_q <= '0;
      end else begin
        if (push_ok) wp_q <= wp_q + DEPTH_LOG2'(1);
        if (pop) rp_q <= rp_q + DEPTH_LOG2'(1);
        cnt_q <= cnt_q + CW'(push_ok) - CW'(pop);
      end
      ovf_q <= ovf_set || (ovf_q && !(bus_wr && bus_addr == 2'd1 && bus_wdata[2]));
      err_q <= err_set || (err_q && !(bus_wr && bus_addr == 2'd1 && bus_wdata[3]));
      if (bus_wr && bus_addr == 2'd2) irq_en_q <= bus_wdata[0];
      if (rd_en) rdata_q <= rdata_d;
      irq_q <= irq_en_q && (ne || ovf_q || err_q);
    end
  end
  assign uart_ack = ack_q;
  assign bus_rdata = rdata_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_nexi_uart_rx_ctrl.sv
// tb_nexi_uart_rx_ctrl: directed scenario bench for the UART receive controller
module tb_nexi_uart_rx_ctrl;
  logic clk = 0, rst = 1, uart_ready = 0, bus_rd = 0, bus_wr = 0;
  logic [7:0] uart_data = 0, bus_wdata = 0;
  logic [1:0] bus_addr = 0;
  logic uart_ack, irq;
  logic [7:0] bus_rdata;
  int n_chk = 0, n_fail = 0;
  logic [7:0] v;
  nexi_uart_rx_ctrl #(.DEPTH_LOG2(3), .ACK_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .uart_data(uart_data), .uart_ready(uart_ready), .uart_ack(uart_ack),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    bus_rd = 1; bus_addr = a;
    tick();
    bus_rd = 0;
    d = bus_rdata;
  endtask
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    bus_wr = 1; bus_addr = a; bus_wdata = d;
    tick();
    bus_wr = 0;
  endtask
  task automatic send_byte(input logic [7:0] d);
    int n;
    uart_data = d; uart_ready = 1;
    n = 0;
    do begin tick(); n++; end while (!uart_ack && n < 10);
    uart_ready = 0;
    n_chk++;
    if (!uart_ack) begin n_fail++; $display("FAIL send_ack_rise byte=%h ack=%b want 1", d, uart_ack); end
    n = 0;
    do begin tick(); n++; end while (uart_ack && n < 10);
    n_chk++;
    if (uart_ack) begin n_fail++; $display("FAIL send_ack_fall byte=%h ack=%b want 0", d, uart_ack); end
    tick();
  endtask
  task automatic test_reset();
    rst = 1; tick(); tick(); rst = 0;
    n_chk++; if (uart_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", uart_ack); end
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
    n_chk++; if (bus_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got %h want 00", bus_rdata); end
    bus_read(2'd1, v);
    n_chk++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_status got %h want 00", v); end
    bus_read(2'd0, v);
    n_chk++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_rxdata got %h want 00", v); end
  endtask
  task automatic test_single();
    uart_data = 8'hA5; uart_ready = 1;
    tick();
    n_chk++; if (uart_ack !== 1'b1) begin n_fail++; $display("FAIL single_ack_latency got %b want 1", uart_ack); end
    tick(); tick();
    n_chk++; if (uart_ack !== 1'b1) begin n_fail++; $display("FAIL single_ack_hold got %b want 1", uart_ack); end
    uart_ready = 0;
    tick();
    n_chk++; if (uart_ack !== 1'b0) begin n_fail++; $display("FAIL single_ack_drop got %b want 0", uart_ack); end
    tick();
    bus_read(2'd1, v);
    n_chk++; if (v !== 8'h11) begin n_fail++; $display("FAIL single_status got %h want 11", v); end
    bus_read(2'd0, v);
    n_chk++; if (v !== 8'hA5) begin n_fail++; $display("FAIL single_rxdata got %h want a5", v); end
    bus_read(2'd1, v);
    n_chk++; if (v !== 8'h00) begin n_fail++; $display("FAIL single_status_empty got %h want 00", v); end
    bus_read(2'd3, v);
    n_chk++; if (v !== 8'h00) begin n_fail++; $display("FAIL reserved_read got %h want 00", v); end
  endtask
  task automatic test_fill_overflow();
    for (int i = 0; i < 9; i++) send_byte(8'(i));
    bus_read(2'd1, v);
    n_chk++; if (v !== 8'h87) begin n_fail++; $display("FAIL fill_status got %h want 87", v); end
    for (int i = 0; i < 8; i++) begin
      bus_read(2'd0, v);
      n_chk++; if (v !== 8'(i)) begin n_fail++; $display("FAIL fill_pop%0d got %h want %h", i, v, 8'(i)); end
    end
    bus_read(2'd1, v);
    n_chk++; if (v !== 8'h04) begin n_fail++; $display("FAIL ovf_sticky got %h want 04", v); end
    bus_write(2'd1, 8'h04);
    bus_read(2'd1, v);
    n_chk++; if (v !== 8'h00) begin n_fail++; $display("FAIL ovf_clear got %h want 00", v); end
  endtask
  task automatic test_simultaneous();
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
    uart_data = 8'h5A; uart_ready = 1; bus_rd = 1; bus_addr = 2'd0;
    tick();
    bus_rd = 0; uart_ready = 0;
    n_chk++; if (bus_rdata !== 8'h10) begin n_fail++; $display("FAIL simul_rdata got %h want 10", bus_rdata); end
    n_chk++; if (uart_ack !== 1'b1) begin n_fail++; $display("FAIL simul_ack got %b want 1", uart_ack); end
    tick(); tick();
    bus_read(2'd1, v);
    n_chk++; if (v !== 8'h83) begin n_fail++; $display("FAIL simul_status got %h want 83", v); end
    for (int i = 1; i < 8; i++) begin
      bus_read(2'd0, v);
      n_chk++; if (v !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL simul_pop%0d got %h want %h", i, v, 8'h10 + 8'(i)); end
    end
    bus_read(2'd0, v);
    n_chk++; if (v !== 8'h5A) begin n_fail++; $display("FAIL simul_last got %h want 5a", v); end
  endtask
  task automatic test_stuck();
    int hi;
    bus_write(2'd2, 8'h01);
    bus_read(2'd2, v);
    n_chk++; if (v !== 8'h01) begin n_fail++; $display("FAIL ctrl_read got %h want 01", v); end
    uart_data = 8'hC3; uart_ready = 1;
    hi = 0;
    tick();
    while (uart_ack && hi < 300) begin hi++; tick(); end
    n_chk++; if (hi != 64) begin n_fail++; $display("FAIL stuck_ack_cycles got %0d want 64", hi); end
    bus_read(2'd1, v);
    n_chk++; if (v !== 8'h19) begin n_fail++; $display("FAIL stuck_status got %h want 19", v); end
    n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL stuck_irq got %b want 1", irq); end
    tick();
    n_chk++; if (uart_ack !== 1'b1) begin n_fail++; $display("FAIL stuck_recapture got %b want 1", uart_ack); end
    uart_ready = 0;
    tick(); tick();
    bus_write(2'd1, 8'h08);
    bus_write(2'd2, 8'h03);
    bus_read(2'd1, v);
    n_chk++; if (v !== 8'h00) begin n_fail++; $display("FAIL stuck_cleanup got %h want 00", v); end
  endtask
  task automatic test_flush_reset();
    bus_write(2'd2, 8'h00);
    for (int i = 0; i < 3; i++) send_byte(8'h30 + 8'(i));
    bus_read(2'd1, v);
    n_chk++; if (v !== 8'h31) begin n_fail++; $display("FAIL flush_pre got %h want 31", v); end
    bus_write(2'd2, 8'h02);
    bus_read(2'd1, v);
    n_chk++; if (v !== 8'h00) begin n_fail++; $display("FAIL flush_status got %h want 00", v); end
    bus_read(2'd2, v);
    n_chk++; if (v !== 8'h00) begin n_fail++; $display("FAIL flush_ctrl got %h want 00", v); end
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL flush_irq got %b want 0", irq); end
    uart_data = 8'h77; uart_ready = 1;
    tick();
    n_chk++; if (uart_ack !== 1'b1) begin n_fail++; $display("FAIL rst_pre_ack got %b want 1", uart_ack); end
    rst = 1;
    tick();
    rst = 0;
    n_chk++; if (uart_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack_drop got %b want 0", uart_ack); end
    tick();
    n_chk++; if (uart_ack !== 1'b1) begin n_fail++; $display("FAIL rst_recapture got %b want 1", uart_ack); end
    uart_ready = 0;
    tick(); tick();
    bus_read(2'd1, v);
    n_chk++; if (v !== 8'h11) begin n_fail++; $display("FAIL rst_status got %h want 11", v); end
    bus_read(2'd0, v);
    n_chk++; if (v !== 8'h77) begin n_fail++; $display("FAIL rst_rxdata got %h want 77", v); end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_simultaneous();
    test_stuck();
    test_flush_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
